// File: rtl/div_pkg.sv
// div_pkg: shared constants and state encoding for the sequential divider.
package div_pkg;

    localparam int unsigned WIDTH = 16;

    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/sub_borrow.sv
// sub_borrow: combinational trial subtractor for one restoring-division step.
module sub_borrow #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // The divider keeps x < 2*y with y's MSB clear, so the sign bit of the
    // W-bit difference is exactly the borrow.
    assign diff   = x - y;
    assign borrow = diff[W-1];

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per RUN cycle.
// Define DIV_SIGNED_EN for two's-complement operands (truncation toward zero).
module div_seq #(
    parameter int unsigned WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);
    import div_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] pr_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             divz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_diff_msb;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
    logic negq_q;
    logic negr_q;

    assign a_mag    = a[WIDTH-1] ? -a : a;
    assign b_mag    = b[WIDTH-1] ? -b : b;
    assign quot_fix = negq_q ? -dq_q : dq_q;
    assign rem_fix  = negr_q ? -pr_q : pr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (state_q == IDLE && start && b != '0) begin
            negq_q <= a[WIDTH-1] ^ b[WIDTH-1];
            negr_q <= a[WIDTH-1];
        end
    end
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign quot_fix = dq_q;
    assign rem_fix  = pr_q;
`endif

    // dq_q starts as the dividend and fills with quotient bits from the right.
    assign shifted = {pr_q, dq_q[WIDTH-1]};

    sub_borrow #(.W(WIDTH + 1)) u_sub (
        .x      (shifted),
        .y      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (b == '0) ? DONE : RUN;
            RUN:  if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pr_q   <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            divz_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divz_q <= (b == '0);
                        if (b == '0) begin
                            quot_q <= DIV_ZERO_QUOT;
                            rem_q  <= a;
                        end else begin
                            pr_q  <= '0;
                            dq_q  <= a_mag;
                            dvs_q <= b_mag;
                            cnt_q <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    pr_q  <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    dq_q  <= {dq_q[WIDTH-2:0], ~borrow};
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    quot_q <= quot_fix;
                    rem_q  <= rem_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q == RUN) || (state_q == FIX);
    assign done     = (state_q == DONE);
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign div_zero = divz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random checks of div_seq against an arithmetic model.
// Honours DIV_SIGNED_EN the same way as the design.
module tb_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    div_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] ia, input logic [15:0] ib,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic ez);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        if (ib == 16'd0) begin
            eq = 16'hFFFF;
            er = ia;
            ez = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(ia);
            sb = $signed(ib);
            eq = 16'(sa / sb);
            er = 16'(sa % sb);
`else
            eq = ia / ib;
            er = ia % ib;
`endif
            ez = 1'b0;
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic launch(input logic [15:0] ia, input logic [15:0] ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) check_eq("done_timeout", done, 1);
    endtask

    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input string tag);
        int lat;
        int bc;
        launch(ia, ib);
        wait_done(lat, bc);
        check_eq({tag, "_quot"}, quot, eq);
        check_eq({tag, "_rem"}, rem, er);
        check_eq({tag, "_divz"}, div_zero, ez);
        check_eq({tag, "_latency"}, lat, ez ? 1 : 18);
        check_eq({tag, "_busy_cycles"}, bc, ez ? 0 : 17);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int lat;
        int bc;
        int extra_done;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_quot", quot, 0);
        check_eq("rst_rem", rem, 0);
        check_eq("rst_divz", div_zero, 0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases and boundaries.
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, "d100_7");
        do_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, "dzero");
        do_op(16'd0, 16'd1234, 16'd0, 16'd0, 1'b0, "a_zero");
        do_op(16'd4321, 16'd1, 16'd4321, 16'd0, 1'b0, "b_one");
        do_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, "ffff_ffff");
        do_op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, "a_lt_b");
        do_op(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, "d20_6");
`ifdef DIV_SIGNED_EN
        do_op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, "s_m7_2");
        do_op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, "s_7_m2");
        do_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, "s_min_m1");
        do_op(16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, "s_dzero");
`else
        do_op(16'd3, 16'hFFFF, 16'd0, 16'd3, 1'b0, "u_3_ffff");
        do_op(16'hFFFE, 16'hFFFF, 16'd0, 16'hFFFE, 1'b0, "u_fffe_ffff");
        do_op(16'h8000, 16'd3, 16'h2AAA, 16'd2, 1'b0, "u_8000_3");
`endif

        // Back-to-back: second request held high across the DONE cycle.
        launch(16'hFFFF, 16'd1);
        wait_done(lat, bc);
        check_eq("b2b1_quot", quot, 16'hFFFF);
        check_eq("b2b1_rem", rem, 16'd0);
        a     = 16'd3;
        b     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        check_eq("b2b_not_in_done", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("b2b_accepted", busy, 1);
        wait_done(lat, bc);
`ifdef DIV_SIGNED_EN
        check_eq("b2b2_quot", quot, 16'hFFFD);
        check_eq("b2b2_rem", rem, 16'd0);
`else
        check_eq("b2b2_quot", quot, 16'd0);
        check_eq("b2b2_rem", rem, 16'd3);
`endif
        @(posedge clk); #1;

        // A start while busy is dropped.
        launch(16'd100, 16'd7);
        repeat (3) @(posedge clk);
        #1;
        a     = 16'd9;
        b     = 16'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc);
        check_eq("ign_quot", quot, 16'd14);
        check_eq("ign_rem", rem, 16'd2);
        check_eq("ign_divz", div_zero, 0);
        extra_done = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra_done++;
        end
        check_eq("ign_extra_done", extra_done, 0);
        check_eq("ign_hold_quot", quot, 16'd14);
        check_eq("ign_hold_rem", rem, 16'd2);

        // Asynchronous reset in the middle of an operation.
        launch(16'd100, 16'd7);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_quot", quot, 0);
        check_eq("mid_rst_rem", rem, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra_done = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        check_eq("mid_rst_no_resume", extra_done, 0);
        do_op(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, "post_rst");

        // Random operands, biased toward zero and small divisors.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 16'd0;
                1:       rb = 16'd1;
                2, 3, 4: rb = 16'($urandom_range(1, 255));
                default: rb = 16'($urandom);
            endcase
            model(ra, rb, eq, er, ez);
            do_op(ra, rb, eq, er, ez, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
